// File: rtl/csr_led_pwm_pkg.sv
// Shared CSR definitions for the LED PWM block: modify encodings, register
// offsets and the read-modify-write helper used by every CSR field.
package csr_led_pwm_pkg;

    typedef enum logic [1:0] {
        MOD_NONE  = 2'b00,
        MOD_WRITE = 2'b01,
        MOD_SET   = 2'b10,
        MOD_CLEAR = 2'b11
    } csr_modify_e;

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_DUTY   = 2'd1;
    localparam logic [1:0] OFF_BLINK  = 2'd2;
    localparam logic [1:0] OFF_PERIOD = 2'd3;

    function automatic logic [31:0] csr_apply(input logic [31:0] old_val,
                                              input logic [31:0] operand,
                                              input logic [1:0]  modify);
        logic [31:0] res;
        res = old_val;
        case (modify)
            MOD_WRITE: res = operand;
            MOD_SET:   res = old_val | operand;
            MOD_CLEAR: res = old_val & ~operand;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_led_pwm_blink.sv
// Blink timer: counts up to the programmed period, then wraps and toggles
// the blink phase; a restart reloads the count and forces the phase high.
module led_blink_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] period,
    input  logic        restart,
    output logic        phase
);

    logic [23:0] cnt_p0;

    // >= rather than == so a period shrunk below the running count expires at once
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_p0 <= 24'd0;
            phase  <= 1'b1;
        end else if (cnt_p0 >= period) begin
            cnt_p0 <= 24'd0;
            phase  <= ~phase;
        end else begin
            cnt_p0 <= cnt_p0 + 24'd1;
        end
    end

endmodule

// File: rtl/csr_led_pwm.sv
// CSR-controlled LED driver: per-LED enable, global PWM dimming and
// per-LED blink, with a four-register CSR window at BASE_ADDR.
module csr_led_pwm
    import csr_led_pwm_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR    = 12'h7c1,
    parameter int          N_LEDS       = 8,
    parameter int          PWM_BITS     = 8,
    parameter logic [31:0] LED_RESET    = 32'h81,
    parameter logic [23:0] PERIOD_RESET = 24'd5_999_999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic [1:0]        modify,
    input  logic [31:0]       wdata,
    input  logic [11:0]       addr,
    output logic [31:0]       rdata,
    output logic              valid,
    output logic [N_LEDS-1:0] leds
);

    localparam logic [PWM_BITS:0]   DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [PWM_BITS-1:0] PWM_ONE   = 1;
    localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

    logic [N_LEDS-1:0]   led_q;
    logic [PWM_BITS:0]   duty_q;
    logic [PWM_BITS:0]   duty_act;
    logic [N_LEDS-1:0]   blink_q;
    logic [23:0]         period_q;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic [11:0] addr_off;
    logic        hit;
    logic [1:0]  sel;
    logic        we;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        pwm_phase;
    logic        blink_phase;
    logic        unused;

    // Offset subtraction makes the window check a simple upper-bits-zero test
    assign addr_off = addr - BASE_ADDR;
    assign hit      = (addr_off[11:2] == 10'd0);
    assign sel      = addr_off[1:0];
    assign we       = hit && (modify != MOD_NONE);
    assign unused   = ^{read, new_val};

    always_comb begin
        old_val = '0;
        case (sel)
            OFF_LED:    old_val[N_LEDS-1:0]   = led_q;
            OFF_DUTY:   old_val[PWM_BITS:0]   = duty_q;
            OFF_BLINK:  old_val[N_LEDS-1:0]   = blink_q;
            default:    old_val[23:0]         = period_q;
        endcase
    end

    assign new_val   = csr_apply(old_val, wdata, modify);
    assign pwm_phase = ({1'b0, pwm_cnt} < duty_act);

    // Stage p0: CSR registers, PWM counter and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q    <= LED_RESET[N_LEDS-1:0];
            duty_q   <= DUTY_FULL;
            duty_act <= DUTY_FULL;
            blink_q  <= '0;
            period_q <= PERIOD_RESET;
            pwm_cnt  <= '0;
            valid    <= 1'b0;
            rdata    <= '0;
        end else begin
            if (we && sel == OFF_LED)    led_q    <= new_val[N_LEDS-1:0];
            if (we && sel == OFF_DUTY)   duty_q   <= new_val[PWM_BITS:0];
            if (we && sel == OFF_BLINK)  blink_q  <= new_val[N_LEDS-1:0];
            if (we && sel == OFF_PERIOD) period_q <= new_val[23:0];
            pwm_cnt <= pwm_cnt + PWM_ONE;
            // Duty only changes at the period boundary so no PWM cycle is glitched
            if (pwm_cnt == PWM_MAX) duty_act <= duty_q;
            valid <= hit;
            rdata <= hit ? old_val : 32'd0;
        end
    end

    led_blink_timer u_blink (
        .clk     (clk),
        .rst     (rst),
        .period  (period_q),
        .restart (we && sel == OFF_PERIOD),
        .phase   (blink_phase)
    );

    // Stage p1: registered LED drive
    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else begin
            leds <= led_q & {N_LEDS{pwm_phase}} & (~blink_q | {N_LEDS{blink_phase}});
        end
    end

endmodule

// File: tb/tb_csr_led_pwm.sv
// Directed self-checking bench for csr_led_pwm with default parameters.
module tb_csr_led_pwm;
    import csr_led_pwm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic [1:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        v;

    always #5 clk = ~clk;

    csr_led_pwm dut (
        .clk    (clk),
        .rst    (rst),
        .read   (read),
        .modify (modify),
        .wdata  (wdata),
        .addr   (addr),
        .rdata  (rdata),
        .valid  (valid),
        .leds   (leds)
    );

    task automatic csr_op(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        @(negedge clk);
        addr   = a;
        modify = m;
        wdata  = d;
        read   = (m == MOD_NONE);
        @(posedge clk);
        #1;
        rd     = rdata;
        v      = valid;
        addr   = 12'h000;
        modify = MOD_NONE;
        wdata  = 32'd0;
        read   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 12'h000; modify = MOD_NONE; wdata = 32'd0; read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (leds !== 8'h81) begin errors++; $display("FAIL post_reset_leds got %h want 81", leds); end
        csr_op(12'h7c1, MOD_NONE, 32'd0);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL read_led_valid got %b want 1", v); end
        checks++; if (rd !== 32'h81) begin errors++; $display("FAIL read_led_rdata got %h want 81", rd); end
    endtask

    task automatic test_reset_values();
        csr_op(12'h7c2, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL reset_duty got %h want 100", rd); end
        csr_op(12'h7c3, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_blink got %h want 0", rd); end
        csr_op(12'h7c4, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h5B8D7F) begin errors++; $display("FAIL reset_period got %h want 5b8d7f", rd); end
    endtask

    task automatic test_led_modify();
        csr_op(12'h7c1, MOD_WRITE, 32'h0F);
        checks++; if (rd !== 32'h81) begin errors++; $display("FAIL led_write_prior got %h want 81", rd); end
        csr_op(12'h7c1, MOD_SET, 32'h30);
        checks++; if (rd !== 32'h0F) begin errors++; $display("FAIL led_set_prior got %h want 0f", rd); end
        csr_op(12'h7c1, MOD_CLEAR, 32'h01);
        checks++; if (rd !== 32'h3F) begin errors++; $display("FAIL led_clear_prior got %h want 3f", rd); end
        csr_op(12'h7c1, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h3E) begin errors++; $display("FAIL led_final got %h want 3e", rd); end
    endtask

    task automatic test_non_hit();
        csr_op(12'h7c5, MOD_WRITE, 32'hFF);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL nonhit_valid got %b want 0", v); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL nonhit_rdata got %h want 0", rd); end
        csr_op(12'h7c0, MOD_WRITE, 32'hFF);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL below_base_valid got %b want 0", v); end
        csr_op(12'h7c1, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h3E) begin errors++; $display("FAIL nonhit_led_kept got %h want 3e", rd); end
        csr_op(12'h7c4, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h5B8D7F) begin errors++; $display("FAIL nonhit_period_kept got %h want 5b8d7f", rd); end
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0 || rdata !== 32'd0) begin
            errors++; $display("FAIL idle_after_hit got valid=%b rdata=%h want 0/0", valid, rdata);
        end
    endtask

    task automatic test_field_width();
        csr_op(12'h7c1, MOD_WRITE, 32'hFFFF_FF3C);
        csr_op(12'h7c1, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL led_width got %h want 3c", rd); end
        csr_op(12'h7c2, MOD_WRITE, 32'hFFFF_FFFF);
        csr_op(12'h7c2, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h1FF) begin errors++; $display("FAIL duty_width got %h want 1ff", rd); end
        csr_op(12'h7c1, MOD_WRITE, 32'hFF);
    endtask

    task automatic test_pwm();
        logic [7:0] prev;
        int guard;
        int found;
        int hi_a;
        int hi_b;
        csr_op(12'h7c2, MOD_WRITE, 32'd64);
        csr_op(12'h7c2, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'd64) begin errors++; $display("FAIL duty_readback got %0d want 64", rd); end
        prev = leds; guard = 0; found = 0;
        while (found == 0 && guard < 1000) begin
            @(posedge clk);
            #1;
            if (prev == 8'h00 && leds == 8'hFF) found = 1;
            prev = leds;
            guard++;
        end
        checks++; if (found != 1) begin errors++; $display("FAIL pwm_rising_edge got none want edge within 1000 cycles"); end
        hi_a = 0; hi_b = 0;
        for (int j = 0; j < 512; j++) begin
            @(negedge clk);
            if (j == 100) begin
                addr = 12'h7c2; modify = MOD_WRITE; wdata = 32'd128;
            end else begin
                addr = 12'h000; modify = MOD_NONE; wdata = 32'd0;
            end
            @(posedge clk);
            #1;
            if (leds == 8'hFF) begin
                if (j < 256) hi_a++;
                else hi_b++;
            end
        end
        addr = 12'h000; modify = MOD_NONE;
        checks++; if (hi_a != 64) begin errors++; $display("FAIL pwm_duty64_high got %0d want 64", hi_a); end
        checks++; if (hi_b != 128) begin errors++; $display("FAIL pwm_duty128_high got %0d want 128", hi_b); end
        csr_op(12'h7c2, MOD_WRITE, 32'h100);
        repeat (300) @(posedge clk);
        #1;
        checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL pwm_full_on got %h want ff", leds); end
    endtask

    task automatic test_blink();
        logic exp0;
        csr_op(12'h7c3, MOD_WRITE, 32'h01);
        csr_op(12'h7c4, MOD_WRITE, 32'd9);
        checks++; if (rd !== 32'h5B8D7F) begin errors++; $display("FAIL period_prior got %h want 5b8d7f", rd); end
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            exp0 = (((k - 1) / 10) % 2 == 0);
            checks++; if (leds !== {7'h7F, exp0}) begin
                errors++; $display("FAIL blink_cycle_%0d got %h want %h", k, leds, {7'h7F, exp0});
            end
        end
        csr_op(12'h7c4, MOD_WRITE, 32'd9);
        checks++; if (rd !== 32'd9) begin errors++; $display("FAIL period_readback got %0d want 9", rd); end
        checks++; if (leds !== 8'hFE) begin errors++; $display("FAIL blink_low_before_restart got %h want fe", leds); end
        @(posedge clk);
        #1;
        checks++; if (leds !== 8'hFF) begin errors++; $display("FAIL blink_restart_high got %h want ff", leds); end
    endtask

    task automatic test_reset_dominance();
        @(negedge clk);
        rst = 1'b1; addr = 12'h7c1; modify = MOD_WRITE; wdata = 32'hFF;
        @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_write_valid got %b want 0", valid); end
        rst = 1'b0; addr = 12'h000; modify = MOD_NONE; wdata = 32'd0;
        csr_op(12'h7c1, MOD_NONE, 32'd0);
        checks++; if (rd !== 32'h81) begin errors++; $display("FAIL rst_dominates got %h want 81", rd); end
    endtask

    initial begin
        test_reset();
        test_reset_values();
        test_led_modify();
        test_non_hit();
        test_field_width();
        test_pwm();
        test_blink();
        test_reset_dominance();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
